// File: rtl/seq_div_4b_if.sv
// Operand/result bundle for the sequential divider. The ovf field exists only
// when SEQ_DIV_OVF_EN is defined.
interface seq_div_4b_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) ();
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
`ifdef SEQ_DIV_OVF_EN
    logic                  ovf;
`endif

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
`ifdef SEQ_DIV_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
`ifdef SEQ_DIV_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/seq_div_4b.sv
// Restoring divider, one quotient bit per clock behind start/busy/done.
// Optional SEQ_DIV_OVF_EN adds ovf: quotient does not fit in DIVISOR_W bits.
module seq_div_4b #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input logic          clk,
    input logic          rst,
    seq_div_4b_if.slave  div
);
    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state, state_nxt;
    logic [DIVIDEND_W-1:0] dvd_sh;
    logic [DIVIDEND_W-1:0] quo_sh;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W-1:0]  rem_w;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;
    logic                  dbz_r;
    logic                  accept;
    logic                  last;
    logic                  q_bit;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [DIVIDEND_W-1:0] quo_nxt;

    // The shifted partial remainder is one bit wider than the divisor; after a
    // conditional subtract it always fits back into DIVISOR_W bits.
    function automatic logic [DIVISOR_W:0] div_step(
        input logic [DIVISOR_W-1:0] r,
        input logic                 b,
        input logic [DIVISOR_W-1:0] d
    );
        logic [DIVISOR_W:0]   r_sh;
        logic [DIVISOR_W-1:0] diff;
        r_sh = {r, b};
        diff = r_sh[DIVISOR_W-1:0] - d;
        if (r_sh >= {1'b0, d}) div_step = {1'b1, diff};
        else                   div_step = {1'b0, r_sh[DIVISOR_W-1:0]};
    endfunction

    assign {q_bit, rem_nxt} = div_step(rem_w, dvd_sh[DIVIDEND_W-1], dvs);
    assign quo_nxt = (quo_sh << 1) | DIVIDEND_W'(q_bit);
    assign accept  = div.start && ((state == IDLE) || (state == DONE));
    assign last    = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (div.start) state_nxt = (div.divisor == '0) ? DONE : CALC;
            end
            CALC:    if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_sh      <= '0;
            quo_sh      <= '0;
            dvs         <= '0;
            rem_w       <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else if (accept) begin
            dvd_sh <= div.dividend;
            dvs    <= div.divisor;
            quo_sh <= '0;
            rem_w  <= '0;
            cnt    <= '0;
            if (div.divisor == '0) begin
                quotient_r  <= '1;
                remainder_r <= '0;
                dbz_r       <= 1'b1;
            end
        end else if (state == CALC) begin
            dvd_sh <= dvd_sh << 1;
            quo_sh <= quo_nxt;
            rem_w  <= rem_nxt;
            cnt    <= cnt + 1'b1;
            if (last) begin
                quotient_r  <= quo_nxt;
                remainder_r <= rem_nxt;
                dbz_r       <= 1'b0;
            end
        end
    end

`ifdef SEQ_DIV_OVF_EN
    logic ovf_r;

    always_ff @(posedge clk) begin
        if (rst)                                  ovf_r <= 1'b0;
        else if (accept && (div.divisor == '0))   ovf_r <= 1'b0;
        else if ((state == CALC) && last)         ovf_r <= |quo_nxt[DIVIDEND_W-1:DIVISOR_W];
    end

    assign div.ovf = ovf_r;
`endif

    assign div.busy        = (state == CALC);
    assign div.done        = (state == DONE);
    assign div.quotient    = quotient_r;
    assign div.remainder   = remainder_r;
    assign div.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_div_4b.sv
// Scoreboard bench for seq_div_4b: directed operands with hand-computed results.
// Build with +define+SEQ_DIV_OVF_EN to also check the ovf output.
module tb_seq_div_4b;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_div_4b_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) dif ();

    seq_div_4b #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .div (dif.slave)
    );

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        logic       ovf;
        int         busy;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   busy_run = 0;
    bit   last_rst = 1'b0;
    bit   fin = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at posedge+2; the following posedge is the start edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] q, input logic [3:0] r,
                         input logic dbz, input logic ovf);
        exp_t e;
        e.q    = q;
        e.r    = r;
        e.dbz  = dbz;
        e.ovf  = ovf;
        e.busy = (b == 4'd0) ? 0 : 8;
        e.cyc  = cyc + ((b == 4'd0) ? 1 : 9);
        sb.push_back(e);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk); #2;
        dif.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (dif.done) break;
            @(posedge clk); #2;
        end
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    // Stimulus
    initial begin
        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        step();

        issue(8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 1'b0);
        wait_done(); step();

        // Operands wiggle and start is re-pulsed during CALC.
        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1);
        dif.dividend = 8'h11;
        dif.divisor  = 4'd3;
        step();
        dif.start    = 1'b1;
        dif.dividend = 8'hFF;
        dif.divisor  = 4'd1;
        step();
        dif.start = 1'b0;
        wait_done(); step();

        // Back-to-back: second start lands in the DONE cycle.
        issue(8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 1'b0);
        wait_done();
        issue(8'd0, 4'd1, 8'd0, 4'd0, 1'b0, 1'b0);
        wait_done(); step();

        issue(8'h5A, 4'd0, 8'hFF, 4'd0, 1'b1, 1'b0);
        wait_done(); step();
        issue(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 1'b0);
        wait_done(); step();

        issue(8'd5, 4'd0, 8'hFF, 4'd0, 1'b1, 1'b0);
        wait_done(); step();
        issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b1);
        wait_done(); step();

        // Abort: reset in the 4th CALC cycle, no result expected.
        dif.start    = 1'b1;
        dif.dividend = 8'd143;
        dif.divisor  = 4'd11;
        step();
        dif.start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (12) step();

        issue(8'd100, 4'd9, 8'd11, 4'd1, 1'b0, 1'b0);
        wait_done();
        repeat (3) step();
        fin = 1'b1;
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (last_rst) begin
                chk("rst_busy", int'(dif.busy), 0);
                chk("rst_done", int'(dif.done), 0);
                chk("rst_quotient", int'(dif.quotient), 0);
                chk("rst_remainder", int'(dif.remainder), 0);
                chk("rst_div_by_zero", int'(dif.div_by_zero), 0);
`ifdef SEQ_DIV_OVF_EN
                chk("rst_ovf", int'(dif.ovf), 0);
`endif
                busy_run = 0;
            end
            last_rst = rst;
            if (dif.busy === 1'b1) busy_run++;
            if (dif.done === 1'b1) begin
                chk("done_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("quotient", int'(dif.quotient), int'(e.q));
                    chk("remainder", int'(dif.remainder), int'(e.r));
                    chk("div_by_zero", int'(dif.div_by_zero), int'(e.dbz));
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_cycles", busy_run, e.busy);
`ifdef SEQ_DIV_OVF_EN
                    chk("ovf", int'(dif.ovf), int'(e.ovf));
`endif
                end
                busy_run = 0;
            end
            if (fin || cyc > 3000) begin
                chk("run_finished", int'(fin), 1);
                chk("pending_results", sb.size(), 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end
endmodule
